// File: rtl/id_exe_issue.sv
// id_exe_issue: ID->EXE stage that builds ALU operands and issues them to execute.
// It uses a main output slot and a one-entry skid, so id_ready comes straight from a register.
module id_exe_issue #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 14,
  parameter int DEST_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [XLEN-1:0]     id_rj_value,
  input  logic [XLEN-1:0]     id_rkd_value,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [1:0]          id_src1_sel,
  input  logic                id_src2_imm,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_gr_we,
  input  logic [DEST_W-1:0]   id_dest,
  output logic                exe_valid,
  input  logic                exe_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_src1,
  output logic [XLEN-1:0]     alu_src2,
  output logic [XLEN-1:0]     exe_pc,
  output logic                exe_gr_we,
  output logic [DEST_W-1:0]   exe_dest,
  output logic                op_err
);
  localparam int EW = 3 * XLEN + ALU_OP_W + DEST_W + 2;
  logic [XLEN-1:0] w_src1, w_src2;
  logic [EW-1:0]   w_in, r_main, r_skid;
  logic            r_main_valid, r_skid_valid, w_id_fire, w_exe_fire, w_op_err;
  assign w_src1 = id_src1_sel == 2'b00 ? id_rj_value :
                  id_src1_sel == 2'b01 ? id_pc :
                  id_src1_sel == 2'b10 ? id_imm : '0;
  assign w_src2 = id_src2_imm ? id_imm : id_rkd_value;
  assign w_op_err = $countones(id_alu_op[3:0]) > 1;
  assign w_in = {w_op_err, id_gr_we, id_dest, id_alu_op, id_pc, w_src2, w_src1};
  assign id_ready = ~r_skid_valid;
  assign exe_valid = r_main_valid;
  assign w_id_fire = id_valid & id_ready;
  assign w_exe_fire = r_main_valid & exe_ready;
  assign {op_err, exe_gr_we, exe_dest, alu_op, exe_pc, alu_src2, alu_src1} = r_main;
  // The skid entry always drains into main before any newer instruction can be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid) begin
      if (w_id_fire) begin
        r_main       <= w_in;
        r_main_valid <= 1'b1;
      end
    end else if (w_exe_fire) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (w_id_fire) begin
        r_main <= w_in;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_id_fire) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_id_exe_issue.sv
// tb_id_exe_issue: scoreboard bench for id_exe_issue.
// A queue models the in-flight instructions, and a negedge monitor compares the outputs against that queue.
module tb_id_exe_issue;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [13:0] op;
    logic        we;
    logic [4:0]  dest;
    logic        err;
  } ent_t;
  logic        clk, rst, flush, id_valid, id_ready, id_src2_imm, id_gr_we;
  logic        exe_valid, exe_ready, exe_gr_we, op_err;
  logic [31:0] id_pc, id_rj_value, id_rkd_value, id_imm, alu_src1, alu_src2, exe_pc;
  logic [1:0]  id_src1_sel;
  logic [13:0] id_alu_op, alu_op;
  logic [4:0]  id_dest, exe_dest;
  ent_t        q[$];
  ent_t        act;
  int          n_chk = 0, n_fail = 0;
  bit          m_rdy;
  id_exe_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rj_value(id_rj_value), .id_rkd_value(id_rkd_value), .id_imm(id_imm),
    .id_src1_sel(id_src1_sel), .id_src2_imm(id_src2_imm), .id_alu_op(id_alu_op),
    .id_gr_we(id_gr_we), .id_dest(id_dest), .exe_valid(exe_valid), .exe_ready(exe_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .exe_pc(exe_pc),
    .exe_gr_we(exe_gr_we), .exe_dest(exe_dest), .op_err(op_err)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask
  function automatic ent_t expect_in();
    ent_t e;
    int ones;
    e.pc = id_pc;
    case (id_src1_sel)
      2'd0: e.s1 = id_rj_value;
      2'd1: e.s1 = id_pc;
      2'd2: e.s1 = id_imm;
      default: e.s1 = 32'd0;
    endcase
    e.s2 = id_src2_imm ? id_imm : id_rkd_value;
    e.op = id_alu_op;
    e.we = id_gr_we;
    e.dest = id_dest;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(id_alu_op[i]);
    e.err = ones > 1;
    return e;
  endfunction
  // Reference model: occupancy is the queue length, and the oldest entry must be on the outputs.
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      m_rdy = q.size() < 2;
      chk("exe_valid", exe_valid, q.size() > 0);
      chk("id_ready", id_ready, m_rdy);
      if (q.size() > 0 && exe_valid) begin
        act = {exe_pc, alu_src1, alu_src2, alu_op, exe_gr_we, exe_dest, op_err};
        chk("exe_data", act, q[0]);
      end
      if (flush) q.delete();
      else begin
        if (exe_ready && q.size() > 0) void'(q.pop_front());
        if (id_valid && m_rdy) q.push_back(expect_in());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] pc, input logic [1:0] sel, input logic s2i,
                      input logic [31:0] imm, input logic [13:0] op);
    id_valid = 1;
    id_pc = pc;
    id_src1_sel = sel;
    id_src2_imm = s2i;
    id_imm = imm;
    id_alu_op = op;
    id_rj_value = $urandom;
    id_rkd_value = $urandom;
    id_gr_we = 1'($urandom);
    id_dest = 5'($urandom);
  endtask
  task automatic send_rand();
    logic [13:0] op;
    op = $urandom_range(3) == 0 ? 14'd0 : $urandom_range(1) == 0 ? 14'(1 << $urandom_range(13)) : 14'($urandom);
    send($urandom, 2'($urandom_range(3)), 1'($urandom), $urandom, op);
  endtask
  initial begin
    rst = 1; flush = 0; id_valid = 0; exe_ready = 0;
    id_pc = 0; id_rj_value = 0; id_rkd_value = 0; id_imm = 0;
    id_src1_sel = 0; id_src2_imm = 0; id_alu_op = 0; id_gr_we = 0; id_dest = 0;
    #12;
    chk("rst_exe_valid", exe_valid, 0);
    chk("rst_id_ready", id_ready, 1);
    chk("rst_data", {exe_pc, alu_src1, alu_src2, alu_op, exe_gr_we, exe_dest, op_err}, 0);
    rst = 0;
    tick();
    exe_ready = 1;
    send(32'h1c000000, 2'b01, 1'b1, 32'd4, 14'h1);
    tick();
    id_valid = 0;
    @(negedge clk);
    chk("t1_valid", exe_valid, 1);
    chk("t1_src1", alu_src1, 32'h1c000000);
    chk("t1_src2", alu_src2, 32'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      send_rand();
      tick();
    end
    id_valid = 0;
    tick(); tick();
    exe_ready = 0;
    send(32'hA0, 2'b01, 1'b0, 0, 14'h1);
    tick();
    send(32'hB0, 2'b01, 1'b0, 0, 14'h8);
    tick();
    id_valid = 0;
    @(negedge clk);
    chk("t3_stall_ready", id_ready, 0);
    chk("t3_stall_pc", exe_pc, 32'hA0);
    tick();
    exe_ready = 1;
    tick();
    @(negedge clk);
    chk("t3_b_pc", exe_pc, 32'hB0);
    chk("t3_ready_back", id_ready, 1);
    tick(); tick();
    exe_ready = 0;
    send_rand(); tick();
    send_rand(); tick();
    send(32'hC0, 2'b00, 1'b0, 0, 14'h4);
    flush = 1;
    tick();
    flush = 0;
    id_valid = 0;
    @(negedge clk);
    chk("t4_valid", exe_valid, 0);
    chk("t4_ready", id_ready, 1);
    exe_ready = 1;
    tick(); tick();
    send(32'h0, 2'b10, 1'b1, 32'h12345000, 14'h2);
    tick();
    id_valid = 0;
    @(negedge clk);
    chk("t5_lu12i", alu_src1, 32'h12345000);
    chk("t5_err0", op_err, 0);
    tick();
    send(32'h44, 2'b11, 1'b0, 32'hFFFF, 14'h9);
    tick();
    id_valid = 0;
    @(negedge clk);
    chk("t5_sel11", alu_src1, 0);
    chk("t5_err1", op_err, 1);
    tick();
    exe_ready = 0;
    send_rand(); tick();
    send_rand(); tick();
    id_valid = 0;
    #2;
    rst = 1;
    #1;
    chk("t6_valid", exe_valid, 0);
    chk("t6_ready", id_ready, 1);
    chk("t6_data", {exe_pc, alu_src1, alu_src2, alu_op, exe_gr_we, exe_dest, op_err}, 0);
    @(negedge clk);
    #2;
    rst = 0;
    tick();
    repeat (3000) begin
      if ($urandom_range(9) < 7) send_rand();
      else id_valid = 0;
      exe_ready = $urandom_range(9) < 6;
      flush = $urandom_range(99) < 3;
      tick();
    end
    id_valid = 0; flush = 0; exe_ready = 1;
    repeat (5) tick();
    @(negedge clk);
    chk("drain_empty", exe_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
